// File: rtl/prescaler_tap_strobe.sv
// Turns one selectable prescaler tap into a single-cycle clock-enable strobe on clkin.
// The strobe counter is built only when PRESCALER_TAP_STROBE_COUNT_EN is defined; otherwise strobe_count is 0.
module prescaler_tap_strobe #(
    parameter int WIDTH       = 8,
    parameter int SEL_WIDTH   = 3,
    parameter int COUNT_WIDTH = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clkin,
    input  logic                   reset_n,
    input  logic [WIDTH-1:0]       taps,
    input  logic [SEL_WIDTH-1:0]   sel,
    input  logic                   sel_load,
    output logic                   strobe,
    output logic                   armed,
    output logic [COUNT_WIDTH-1:0] strobe_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN
    } state_t;

    state_t                 r_state;
    logic [SEL_WIDTH-1:0]   r_active_sel;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_prev;
    logic                   r_strobe;
    logic                   r_armed;

    logic [2**SEL_WIDTH-1:0] w_taps_ext;
    logic                    w_tap;
    logic                    w_edge;
    logic                    w_sel_valid;

    // Pad the tap bus to the full select range so every sel value indexes a real bit.
    always_comb begin
        w_taps_ext            = '0;
        w_taps_ext[WIDTH-1:0] = taps;
    end

    assign w_tap       = w_taps_ext[r_active_sel];
    assign w_edge      = r_sync[SYNC_STAGES-1] & ~r_sync_prev;
    assign w_sel_valid = (sel != '0) && (32'(sel) < WIDTH);

    // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clkin) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_active_sel <= '0;
            r_sync       <= '0;
            r_sync_prev  <= 1'b0;
            r_strobe     <= 1'b0;
            r_armed      <= 1'b0;
        end else begin
            r_strobe    <= 1'b0;
            r_sync      <= {r_sync[SYNC_STAGES-2:0], w_tap};
            r_sync_prev <= r_sync[SYNC_STAGES-1];

            if (sel_load && w_sel_valid) begin
                // NOTE: flushing the chain makes an already-high new tap look like a fresh edge, which ARM swallows.
                r_active_sel <= sel;
                r_sync       <= '0;
                r_sync_prev  <= 1'b0;
                r_armed      <= 1'b0;
                r_state      <= ST_ARM;
            end else if (sel_load && (r_state != ST_IDLE)) begin
                r_active_sel <= '0;
                r_armed      <= 1'b0;
                r_state      <= ST_IDLE;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        r_armed <= 1'b0;
                    end
                    ST_ARM: begin
                        if (w_edge) begin
                            r_armed <= 1'b1;
                            r_state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        r_armed <= 1'b1;
                        if (w_edge) begin
                            r_strobe <= 1'b1;
                        end
                    end
                    default: begin
                        r_armed <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef PRESCALER_TAP_STROBE_COUNT_EN
    logic [COUNT_WIDTH-1:0] r_count;

    // The count is always zero in IDLE, so clearing on any load matches every state's reload rule.
    always_ff @(posedge clkin) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (sel_load) begin
            r_count <= '0;
        end else if ((r_state == ST_RUN) && w_edge) begin
            r_count <= r_count + COUNT_WIDTH'(1);
        end
    end

    assign strobe_count = r_count;
`else
    assign strobe_count = '0;
`endif

    assign strobe = r_strobe;
    assign armed  = r_armed;

endmodule
